// File: rtl/requant_cfg_pkg.sv
// Shared definitions for the requant configuration loader: FSM state encoding
// and the word layout of a quantization parameter record.
package requant_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    FETCH_COMMON = 3'd1,
    LOAD_COMMON  = 3'd2,
    STREAM       = 3'd3,
    FLUSH        = 3'd4,
    DONE         = 3'd5
  } cfg_state_e;

  localparam int unsigned OFF_ACT_MIN  = 0;
  localparam int unsigned OFF_ACT_MAX  = 1;
  localparam int unsigned OFF_DST_OFF  = 2;
  localparam int unsigned OFF_PT_MULT  = 3;
  localparam int unsigned OFF_PT_SHIFT = 4;
  localparam int unsigned OFF_CH_MULT  = 3;

  // Common words fetched before the load pulse, per mode.
  localparam int unsigned N_COMMON_PC = 3;
  localparam int unsigned N_COMMON_PT = 5;

  function automatic int unsigned OFF_CH_SHIFT(input int unsigned vlen);
    return OFF_CH_MULT + vlen;
  endfunction

endpackage

// File: rtl/requant_cfg_loader.sv
// Fetches a quantization parameter record from parameter SRAM and replays it
// onto vec_requant: a common-load pulse, then (per-channel) a serial stream.
module requant_cfg_loader
  import requant_cfg_pkg::*;
#(
  parameter int unsigned VLEN   = 16,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              per_channel,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              cfg_load_common,
  output logic              cfg_per_channel,
  output logic [31:0]       activation_min_out,
  output logic [31:0]       activation_max_out,
  output logic [31:0]       dst_offset_out,
  output logic [31:0]       pt_multiplier_out,
  output logic [31:0]       pt_shift_out,
  output logic              cfg_init_quant,
  output logic              data_valid,
  output logic [31:0]       data_out_s32
);

  localparam int unsigned TOTAL = OFF_CH_SHIFT(VLEN) + VLEN;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_FETCH  = FETCH_COMMON;
  localparam logic [2:0] ST_LOAD   = LOAD_COMMON;
  localparam logic [2:0] ST_STREAM = STREAM;
  localparam logic [2:0] ST_FLUSH  = FLUSH;
  localparam logic [2:0] ST_DONE   = DONE;

  localparam logic [CNT_W-1:0] N_PC  = CNT_W'(N_COMMON_PC);
  localparam logic [CNT_W-1:0] N_PT  = CNT_W'(N_COMMON_PT);
  localparam logic [CNT_W-1:0] N_TOT = CNT_W'(TOTAL);

  logic [2:0]       state, state_d;
  logic             mode;
  logic [CNT_W-1:0] issued, rcv, issue_lim;
  logic             outstanding, accept, req_en, last_common, last_stream;
  logic [31:0]      hold   [N_COMMON_PT];
  logic [31:0]      hold_d [N_COMMON_PT];

  // rvalid without a read in flight is dropped here and never reaches state.
  assign accept      = mem_rvalid && outstanding;
  assign issue_lim   = (state == ST_FETCH) ? (mode ? N_PC : N_PT) : N_TOT;
  assign req_en      = ((state == ST_FETCH) || (state == ST_STREAM)) && (issued != issue_lim);
  // Re-requesting in the rvalid cycle keeps one read in flight at 1 word/cycle.
  assign mem_req     = req_en && (!outstanding || mem_rvalid);
  assign last_common = (rcv == (mode ? N_PC : N_PT) - CNT_W'(1));
  assign last_stream = (rcv == N_TOT - CNT_W'(1));

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  if (accept && last_common) state_d = ST_LOAD;
      ST_LOAD:   state_d = mode ? ST_STREAM : ST_DONE;
      ST_STREAM: if (accept && last_stream) state_d = ST_FLUSH;
      ST_FLUSH:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= ST_IDLE;
      mode            <= 1'b0;
      issued          <= '0;
      rcv             <= '0;
      outstanding     <= 1'b0;
      mem_addr        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cfg_load_common <= 1'b0;
      cfg_init_quant  <= 1'b0;
      data_valid      <= 1'b0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && start) begin
        mode     <= per_channel;
        mem_addr <= base_addr;
        issued   <= '0;
        rcv      <= '0;
      end else begin
        if (mem_req && mem_gnt) begin
          issued   <= issued + CNT_W'(1);
          mem_addr <= mem_addr + ADDR_W'(1);
        end
        if (accept) rcv <= rcv + CNT_W'(1);
      end
      if (mem_req && mem_gnt) outstanding <= 1'b1;
      else if (accept)        outstanding <= 1'b0;
      // Status strobes are decoded from the next state so they are flops.
      busy            <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done            <= (state_d == ST_DONE);
      cfg_load_common <= (state_d == ST_LOAD);
      cfg_init_quant  <= (state_d == ST_STREAM) || (state_d == ST_FLUSH);
      data_valid      <= accept && (state == ST_STREAM);
    end
  end

  always_comb begin
    hold_d = hold;
    if (accept && state == ST_FETCH) begin
      for (int i = 0; i < int'(N_COMMON_PT); i++) begin
        if (rcv == CNT_W'(i)) hold_d[i] = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    hold <= hold_d;
  end

  // Parameter outputs take hold_d so the final common word is already visible
  // during the load pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out_s32       <= '0;
      cfg_per_channel    <= 1'b0;
      activation_min_out <= '0;
      activation_max_out <= '0;
      dst_offset_out     <= '0;
      pt_multiplier_out  <= '0;
      pt_shift_out       <= '0;
    end else begin
      if (accept && state == ST_STREAM) data_out_s32 <= mem_rdata;
      if (state_d == ST_LOAD && state != ST_LOAD) begin
        cfg_per_channel    <= mode;
        activation_min_out <= hold_d[OFF_ACT_MIN];
        activation_max_out <= hold_d[OFF_ACT_MAX];
        dst_offset_out     <= hold_d[OFF_DST_OFF];
        if (!mode) begin
          pt_multiplier_out <= hold_d[OFF_PT_MULT];
          pt_shift_out      <= hold_d[OFF_PT_SHIFT];
        end
      end
    end
  end

endmodule

// File: tb/tb_requant_cfg_loader.sv
// Directed bench for requant_cfg_loader: parameter SRAM responder with optional
// stalls, a cycle-stamped output monitor, and a linear sequence of checks.
module tb_requant_cfg_loader;
  localparam int VLEN   = 16;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0, rstn = 1'b0, start = 1'b0, per_channel = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy, done, mem_req, mem_gnt, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              cfg_load_common, cfg_per_channel, cfg_init_quant, data_valid;
  logic [31:0]       activation_min_out, activation_max_out, dst_offset_out;
  logic [31:0]       pt_multiplier_out, pt_shift_out, data_out_s32;

  requant_cfg_loader #(.VLEN(VLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .per_channel(per_channel),
    .base_addr(base_addr), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .cfg_load_common(cfg_load_common),
    .cfg_per_channel(cfg_per_channel), .activation_min_out(activation_min_out),
    .activation_max_out(activation_max_out), .dst_offset_out(dst_offset_out),
    .pt_multiplier_out(pt_multiplier_out), .pt_shift_out(pt_shift_out),
    .cfg_init_quant(cfg_init_quant), .data_valid(data_valid),
    .data_out_s32(data_out_s32)
  );

  always #5 clk = ~clk;

  int nerr = 0, nchk = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Parameter SRAM responder: gnt gated by gnt_ok, rvalid 1..3 cycles after gnt.
  logic [31:0] mem [0:65535];
  logic        rv = 1'b0, pend = 1'b0, gnt_ok = 1'b1, stall = 1'b0, inj = 1'b0;
  logic [31:0] rd = '0, inj_data = '0;
  logic [15:0] paddr = '0;
  int          wcnt = 0, d = 0, viol = 0;

  assign mem_gnt    = mem_req && gnt_ok;
  assign mem_rvalid = rv | inj;
  assign mem_rdata  = inj ? inj_data : rd;

  always @(posedge clk) gnt_ok <= stall ? ($urandom_range(0, 2) != 0) : 1'b1;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rv <= 1'b0; pend <= 1'b0; wcnt <= 0;
    end else begin
      rv <= 1'b0;
      if (pend) begin
        if (wcnt == 0) begin rv <= 1'b1; rd <= mem[paddr]; pend <= 1'b0; end
        else wcnt <= wcnt - 1;
      end
      if (mem_req && mem_gnt) begin
        if (pend) viol <= viol + 1;
        d = stall ? int'($urandom_range(0, 2)) : 0;
        if (d == 0) begin rv <= 1'b1; rd <= mem[mem_addr]; end
        else begin pend <= 1'b1; paddr <= mem_addr; wcnt <= d - 1; end
      end
    end
  end

  // Output monitor, sampled on the falling edge; rel is the cycle number
  // relative to the cycle in which start was driven (cycle 0).
  int          base_cyc = 0, rel = 0;
  int          lc_cnt, lc_cyc, done_cnt, done_cyc, iq_fall, iq_first, iq_last, iq_hi, ovl;
  int          busy_first, busy_last, req_first, req_last, req_cnt, vr_idx = 0;
  logic        iq_prev = 1'b0, snap_pc;
  logic [31:0] snap [0:4];
  logic [31:0] ch_mult [0:VLEN-1];
  logic [31:0] ch_shift [0:VLEN-1];
  logic [31:0] beats [$];
  int          beat_cyc [$];
  logic [15:0] gaddr [$];

  always @(negedge clk) begin
    rel = cyc - base_cyc;
    if (cfg_load_common) begin
      lc_cnt++; lc_cyc = rel; snap_pc = cfg_per_channel;
      snap[0] = activation_min_out; snap[1] = activation_max_out; snap[2] = dst_offset_out;
      snap[3] = pt_multiplier_out;  snap[4] = pt_shift_out;
    end
    if (cfg_load_common && cfg_init_quant) ovl++;
    if (cfg_init_quant) begin
      if (!iq_prev) begin iq_first = rel; vr_idx = 0; end
      iq_last = rel; iq_hi++;
    end
    if (iq_prev && !cfg_init_quant) iq_fall++;
    iq_prev = cfg_init_quant;
    if (data_valid) begin
      beats.push_back(data_out_s32); beat_cyc.push_back(rel);
      if (cfg_init_quant) begin
        if (vr_idx < VLEN) ch_mult[vr_idx] = data_out_s32;
        else if (vr_idx < 2*VLEN) ch_shift[vr_idx-VLEN] = data_out_s32;
        vr_idx++;
      end
    end
    if (done) begin done_cnt++; done_cyc = rel; end
    if (busy) begin if (busy_first < 0) busy_first = rel; busy_last = rel; end
    if (mem_req) begin if (req_first < 0) req_first = rel; req_last = rel; req_cnt++; end
    if (mem_req && mem_gnt) gaddr.push_back(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    lc_cnt = 0; lc_cyc = -1; done_cnt = 0; done_cyc = -1; iq_fall = 0; iq_first = -1;
    iq_last = -1; iq_hi = 0; ovl = 0; busy_first = -1; busy_last = -1;
    req_first = -1; req_last = -1; req_cnt = 0;
    beats.delete(); beat_cyc.delete(); gaddr.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic launch(input logic pc, input logic [15:0] base);
    clr();
    per_channel = pc; base_addr = base; start = 1'b1; base_cyc = cyc;
    tick(1);
    start = 1'b0; per_channel = 1'b0; base_addr = '0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (done_cnt == 0 && n < lim) begin tick(1); n++; end
    chk(tag, 32'(done_cnt > 0), 32'd1);
    tick(3);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({busy, done, mem_req, cfg_load_common, cfg_per_channel,
                           cfg_init_quant, data_valid}), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_min"}, activation_min_out, 32'd0);
    chk({tag, "_max"}, activation_max_out, 32'd0);
    chk({tag, "_dst"}, dst_offset_out, 32'd0);
    chk({tag, "_ptm"}, pt_multiplier_out, 32'd0);
    chk({tag, "_pts"}, pt_shift_out, 32'd0);
    chk({tag, "_dat"}, data_out_s32, 32'd0);
  endtask

  function automatic logic [31:0] pc_word(input int k);
    return (k < VLEN) ? 32'h100 + 32'(k) : 32'(-(k - VLEN));
  endfunction

  function automatic logic [31:0] wr_word(input int k);
    return (k < VLEN) ? 32'h1000 + 32'(k) : 32'(-(k - VLEN + 1));
  endfunction

  logic [31:0] pt_exp [0:4];
  logic [31:0] pc_com [0:2];
  logic [15:0] a;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr();
    pt_exp = '{32'hFFFF_FF80, 32'h0000_007F, 32'h0000_0005, 32'h4000_0000, 32'hFFFF_FFFE};
    pc_com = '{32'hFFFF_FF9C, 32'h0000_0064, 32'hFFFF_FFFD};
    for (int k = 0; k < 5; k++) mem[16'h0100 + 16'(k)] = pt_exp[k];
    for (int k = 0; k < 3; k++) mem[16'h0200 + 16'(k)] = pc_com[k];
    for (int k = 0; k < 2*VLEN; k++) mem[16'h0203 + 16'(k)] = pc_word(k);
    for (int k = 0; k < 3 + 2*VLEN; k++) begin
      a = 16'hFFFB + 16'(k);
      mem[a] = (k < 3) ? 32'(k + 1) : wr_word(k - 3);
    end

    // Reset state
    tick(3);
    chk_zero("reset");
    @(negedge clk); rstn = 1'b1;
    tick(2);

    // Stray rvalid while idle
    inj_data = 32'hDEAD_BEEF; inj = 1'b1;
    tick(1);
    inj = 1'b0;
    tick(1);
    chk("stray_rvalid_dv", 32'(data_valid), 32'd0);
    chk("stray_rvalid_dat", data_out_s32, 32'd0);
    chk("stray_rvalid_busy", 32'(busy), 32'd0);

    // Per-tensor, zero-wait memory
    launch(1'b0, 16'h0100);
    wait_done("pt_done_seen", 60);
    chk("pt_lc_cyc", 32'(lc_cyc), 32'd7);
    chk("pt_lc_cnt", 32'(lc_cnt), 32'd1);
    for (int k = 0; k < 5; k++) chk($sformatf("pt_param%0d", k), snap[k], pt_exp[k]);
    chk("pt_mode", 32'(snap_pc), 32'd0);
    chk("pt_done_cyc", 32'(done_cyc), 32'd8);
    chk("pt_done_cnt", 32'(done_cnt), 32'd1);
    chk("pt_iq_never", 32'(iq_hi), 32'd0);
    chk("pt_busy_first", 32'(busy_first), 32'd1);
    chk("pt_busy_last", 32'(busy_last), 32'd7);
    chk("pt_req_first", 32'(req_first), 32'd1);
    chk("pt_req_last", 32'(req_last), 32'd5);
    chk("pt_req_cnt", 32'(req_cnt), 32'd5);
    chk("pt_addr0", 32'(gaddr[0]), 32'h0100);
    chk("pt_addr4", 32'(gaddr[4]), 32'h0104);

    // Per-channel, zero-wait, with an extra start pulsed mid-stream
    launch(1'b1, 16'h0200);
    tick(9);
    start = 1'b1; per_channel = 1'b0; base_addr = 16'h0100;
    tick(1);
    start = 1'b0; base_addr = '0;
    wait_done("pc_done_seen", 100);
    tick(10);
    chk("pc_lc_cyc", 32'(lc_cyc), 32'd5);
    chk("pc_mode", 32'(snap_pc), 32'd1);
    for (int k = 0; k < 3; k++) chk($sformatf("pc_common%0d", k), snap[k], pc_com[k]);
    chk("pc_pt_mult_kept", snap[3], 32'h4000_0000);
    chk("pc_pt_shift_kept", snap[4], 32'hFFFF_FFFE);
    chk("pc_beat_cnt", 32'(beats.size()), 32'd32);
    for (int k = 0; k < 2*VLEN; k++) begin
      chk($sformatf("pc_beat%0d", k), beats[k], pc_word(k));
      chk($sformatf("pc_beat_cyc%0d", k), 32'(beat_cyc[k]), 32'(8 + k));
    end
    for (int i = 0; i < VLEN; i++) begin
      chk($sformatf("vr_mult%0d", i), ch_mult[i], 32'h100 + 32'(i));
      chk($sformatf("vr_shift%0d", i), ch_shift[i], 32'(-i));
    end
    chk("pc_iq_first", 32'(iq_first), 32'd6);
    chk("pc_iq_last", 32'(iq_last), 32'd39);
    chk("pc_iq_fall", 32'(iq_fall), 32'd1);
    chk("pc_overlap", 32'(ovl), 32'd0);
    chk("pc_done_cyc", 32'(done_cyc), 32'd40);
    chk("pc_done_cnt_extra_start", 32'(done_cnt), 32'd1);
    chk("pc_busy_last", 32'(busy_last), 32'd39);
    chk("pc_req_first", 32'(req_first), 32'd1);
    chk("pc_req_last", 32'(req_last), 32'd37);
    chk("pc_req_cnt", 32'(req_cnt), 32'd35);
    chk("pc_idle_after", 32'(busy), 32'd0);

    // Per-channel with random gnt/rvalid stalls
    stall = 1'b1;
    launch(1'b1, 16'h0200);
    wait_done("st_done_seen", 600);
    stall = 1'b0;
    tick(5);
    chk("st_beat_cnt", 32'(beats.size()), 32'd32);
    for (int k = 0; k < 2*VLEN; k++) chk($sformatf("st_beat%0d", k), beats[k], pc_word(k));
    chk("st_iq_continuous", 32'(iq_hi), 32'(iq_last - iq_first + 1));
    chk("st_iq_from_stream", 32'(iq_first), 32'(lc_cyc + 1));
    chk("st_iq_to_last_beat", 32'(iq_last), 32'(beat_cyc[2*VLEN-1]));
    chk("st_iq_fall", 32'(iq_fall), 32'd1);
    chk("st_overlap", 32'(ovl), 32'd0);
    chk("st_done_cnt", 32'(done_cnt), 32'd1);
    chk("st_done_after_beat", 32'(done_cyc), 32'(beat_cyc[2*VLEN-1] + 1));

    // Address wrap past 0xFFFF
    launch(1'b1, 16'hFFFB);
    wait_done("wr_done_seen", 100);
    chk("wr_addr4", 32'(gaddr[4]), 32'h0000_FFFF);
    chk("wr_addr5", 32'(gaddr[5]), 32'h0000_0000);
    chk("wr_addr34", 32'(gaddr[34]), 32'h0000_001D);
    chk("wr_common2", snap[2], 32'd3);
    chk("wr_beat_cnt", 32'(beats.size()), 32'd32);
    for (int k = 0; k < 2*VLEN; k++) chk($sformatf("wr_beat%0d", k), beats[k], wr_word(k));

    // Reset mid-STREAM, then a fresh command
    launch(1'b1, 16'h0200);
    tick(14);
    chk("ab_in_stream", 32'(cfg_init_quant), 32'd1);
    rstn = 1'b0;
    #1;
    chk_zero("abort");
    tick(2);
    chk_zero("abort_hold");
    chk("ab_no_done", 32'(done_cnt), 32'd0);
    @(negedge clk); rstn = 1'b1;
    tick(2);
    chk("ab_no_done_after", 32'(done_cnt), 32'd0);
    launch(1'b0, 16'h0100);
    wait_done("ab_done_seen", 60);
    chk("ab_lc_cyc", 32'(lc_cyc), 32'd7);
    for (int k = 0; k < 5; k++) chk($sformatf("ab_param%0d", k), snap[k], pt_exp[k]);
    chk("ab_done_cyc", 32'(done_cyc), 32'd8);
    chk("ab_done_cnt", 32'(done_cnt), 32'd1);

    chk("one_outstanding", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
